// File: rtl/pb_pkg.sv
// Shared definitions for the push-button conditioner: default channel count,
// channel index names and the auto-repeat state encoding.
package pb_pkg;

  localparam int NUM_PB_DEFAULT = 5;

  // Channel indices for the standard five-way button pad
  localparam int PB_UP     = 0;
  localparam int PB_DOWN   = 1;
  localparam int PB_LEFT   = 2;
  localparam int PB_RIGHT  = 3;
  localparam int PB_CENTER = 4;

  // Per-channel auto-repeat state
  typedef enum logic [1:0] {
    RPT_IDLE       = 2'd0,
    RPT_HOLD_DELAY = 2'd1,
    RPT_REPEAT     = 2'd2
  } rpt_state_e;

  // Larger of two integers, used to size shared timers
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One push-button channel: synchronizer, debounce counter, press/release edge
// pulses and, when PB_AUTOREPEAT_EN is defined, an auto-repeat FSM that
// re-issues press pulses while the button stays held.
module pb_channel
  import pb_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on which the next increment would reach DEBOUNCE_CYCLES
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   press_reg, press_next;
  logic                   release_reg;
  logic                   rise, fall;

  // Synchronizer chain: the only place the raw button level is sampled
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], pb_in};
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  // Debounce: count consecutive cycles of disagreement, accept new level on the last one
  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    if (synced != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = synced;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  assign rise = level_next & ~level_reg;
  assign fall = ~level_next & level_reg;

`ifdef PB_AUTOREPEAT_EN
  localparam int TMR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  // Timers count down to zero, so they are loaded one short of the interval
  localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

  rpt_state_e       state_reg, state_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             rpt_pulse;

  // Repeat FSM state and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RPT_IDLE;
      tmr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
    end
  end

  // Repeat FSM next state; a falling level always wins and suppresses any pulse
  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    rpt_pulse  = 1'b0;
    if (fall) begin
      state_next = RPT_IDLE;
      tmr_next   = '0;
    end else begin
      case (state_reg)
        RPT_IDLE: begin
          if (rise) begin
            state_next = RPT_HOLD_DELAY;
            tmr_next   = DELAY_LOAD;
          end
        end
        RPT_HOLD_DELAY, RPT_REPEAT: begin
          if (tmr_reg == '0) begin
            state_next = RPT_REPEAT;
            tmr_next   = PERIOD_LOAD;
            rpt_pulse  = 1'b1;
          end else begin
            tmr_next = tmr_reg - TMR_W'(1);
          end
        end
        default: begin
          state_next = RPT_IDLE;
          tmr_next   = '0;
        end
      endcase
    end
  end

  assign press_next = rise | rpt_pulse;
`else
  // Repeat timing is only meaningful when the repeat feature is built in
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign press_next = rise;
`endif

  // Debounce state and registered edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= fall;
    end
  end

  assign pb_level   = level_reg;
  assign pb_press   = press_reg;
  assign pb_release = release_reg;

endmodule

// File: rtl/pb_conditioner.sv
// Push-button conditioner top: NUM_PB independent pb_channel instances plus
// the combined press indicator. Auto-repeat is built in only when macro
// PB_AUTOREPEAT_EN is defined.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int NUM_PB          = NUM_PB_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] pb_in,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release,
  output logic              pb_any
);

  generate
    for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_ch
      pb_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .pb_in     (pb_in[gi]),
        .pb_level  (pb_level[gi]),
        .pb_press  (pb_press[gi]),
        .pb_release(pb_release[gi])
      );
    end
  endgenerate

  // Any press pulse this cycle, aligned with the registered pulses
  always_comb begin
    pb_any = |pb_press;
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with short debounce/repeat timing.
// Expectations follow whether PB_AUTOREPEAT_EN is defined for the build.
module tb_pb_conditioner;

  localparam int NUM_PB = 5;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int RD     = 20;
  localparam int RP     = 8;
  localparam int LAT    = SYNC + DEB;

`ifdef PB_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NUM_PB-1:0] pb_in;
  logic [NUM_PB-1:0] pb_level;
  logic [NUM_PB-1:0] pb_press;
  logic [NUM_PB-1:0] pb_release;
  logic              pb_any;

  int n_tests = 0;
  int n_fail  = 0;

  pb_conditioner #(
    .NUM_PB         (NUM_PB),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_in     (pb_in),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_any    (pb_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] lvl, input logic [4:0] prs,
                           input logic [4:0] rel, input logic any);
    check({tag, "_level"},   pb_level,   lvl);
    check({tag, "_press"},   pb_press,   prs);
    check({tag, "_release"}, pb_release, rel);
    check({tag, "_any"},     {4'b0, pb_any}, {4'b0, any});
  endtask

  // Expected repeat pulse k cycles after the input edge, press first seen at LAT
  function automatic logic rpt_exp(input int k);
    return RPT_ON && (k >= LAT + RD) && (((k - LAT - RD) % RP) == 0);
  endfunction

  initial begin
    int cnt;

    // Reset with all buttons held: outputs quiet, then a fresh press on all channels
    rst   = 1'b1;
    pb_in = 5'b11111;
    repeat (3) begin
      tick();
      check_all("rst_hold", 5'b0, 5'b0, 5'b0, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check_all("rst_rel_wait", 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_all("rst_rel_press", 5'b11111, 5'b11111, 5'b0, 1'b1);
    tick();
    check_all("rst_rel_after", 5'b11111, 5'b0, 5'b0, 1'b0);
    pb_in = 5'b0;
    repeat (LAT - 1) tick();
    check("all_rel_wait", pb_level, 5'b11111);
    tick();
    check_all("all_release", 5'b0, 5'b0, 5'b11111, 1'b0);
    tick();
    check_all("all_rel_after", 5'b0, 5'b0, 5'b0, 1'b0);
    $display("[TB] reset/held-button step done");

    // Channel 0 held 30 cycles
    repeat (4) tick();
    pb_in = 5'b00001;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("ch0_wait_level", pb_level, 5'b0);
    end
    tick();
    check_all("ch0_press", 5'b00001, 5'b00001, 5'b0, 1'b1);
    cnt = 0;
    for (int k = LAT + 1; k <= 30; k++) begin
      tick();
      if (pb_press[0]) cnt++;
    end
    pb_in = 5'b0;
    for (int k = 31; k < 31 + LAT - 1; k++) begin
      tick();
      if (pb_press[0]) cnt++;
    end
    check("ch0_extra_press_cnt", 5'(cnt), RPT_ON ? 5'd2 : 5'd0);
    tick();
    check_all("ch0_release", 5'b0, 5'b0, 5'b00001, 1'b0);
    tick();
    check_all("ch0_rel_after", 5'b0, 5'b0, 5'b0, 1'b0);
    $display("[TB] channel 0 press/release step done");

    // Channel 2 glitch shorter than the debounce window
    repeat (4) tick();
    for (int k = 1; k <= 13; k++) begin
      pb_in = (k <= 3) ? 5'b00100 : 5'b0;
      tick();
      check_all("ch2_glitch", 5'b0, 5'b0, 5'b0, 1'b0);
    end
    $display("[TB] channel 2 glitch step done");

    // Channel 1 bouncing every 2 cycles, then settled high
    for (int s = 0; s < 6; s++) begin
      pb_in = (s % 2 == 0) ? 5'b00010 : 5'b0;
      repeat (2) begin
        tick();
        check_all("ch1_bounce", 5'b0, 5'b0, 5'b0, 1'b0);
      end
    end
    pb_in = 5'b00010;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check_all("ch1_settle_wait", 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_all("ch1_press", 5'b00010, 5'b00010, 5'b0, 1'b1);
    tick();
    check_all("ch1_after", 5'b00010, 5'b0, 5'b0, 1'b0);
    pb_in = 5'b0;
    repeat (LAT - 1) tick();
    tick();
    check_all("ch1_release", 5'b0, 5'b0, 5'b00010, 1'b0);
    $display("[TB] channel 1 bounce step done");

    // Channel 4 held 60 cycles: repeat train when built in
    repeat (4) tick();
    pb_in = 5'b10000;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("ch4_wait_level", pb_level, 5'b0);
    end
    tick();
    check_all("ch4_press", 5'b10000, 5'b10000, 5'b0, 1'b1);
    for (int k = LAT + 1; k <= 60; k++) begin
      tick();
      check("ch4_hold_press", pb_press, rpt_exp(k) ? 5'b10000 : 5'b0);
      check("ch4_hold_any", {4'b0, pb_any}, {4'b0, rpt_exp(k)});
    end
    pb_in = 5'b0;
    for (int k = 61; k < 61 + LAT - 1; k++) begin
      tick();
      check_all("ch4_drop_wait", 5'b10000, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_all("ch4_release", 5'b0, 5'b0, 5'b10000, 1'b0);
    tick();
    check_all("ch4_rel_after", 5'b0, 5'b0, 5'b0, 1'b0);
    $display("[TB] channel 4 repeat step done");

    // Reset mid-repeat on channel 4: silent abort, then fresh press
    repeat (4) tick();
    pb_in = 5'b10000;
    repeat (LAT - 1) tick();
    tick();
    check_all("ch4r_press", 5'b10000, 5'b10000, 5'b0, 1'b1);
    for (int k = LAT + 1; k <= LAT + 24; k++) begin
      tick();
      check("ch4r_hold_press", pb_press, rpt_exp(k) ? 5'b10000 : 5'b0);
    end
    rst = 1'b1;
    repeat (2) begin
      tick();
      check_all("ch4r_in_reset", 5'b0, 5'b0, 5'b0, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check_all("ch4r_post_reset", 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_all("ch4r_fresh_press", 5'b10000, 5'b10000, 5'b0, 1'b1);
    pb_in = 5'b0;
    repeat (LAT - 1) tick();
    tick();
    check_all("ch4r_release", 5'b0, 5'b0, 5'b10000, 1'b0);
    $display("[TB] reset mid-repeat step done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-length guard
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 SHALL have parameter NUM_PB, default 5, number of push-button channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; minimum 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a new level; minimum 1.
REQ-004 SHALL have parameter REPEAT_DELAY, default 50000000, hold cycles before the first auto-repeat pulse.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port pb_in  input  NUM_PB  raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port pb_level  output  NUM_PB  debounced level per channel.
REQ-010 SHALL have port pb_press  output  NUM_PB  one-cycle press (and repeat) pulse per channel.
REQ-011 SHALL have port pb_release  output  NUM_PB  one-cycle release pulse per channel.
REQ-012 SHALL have port pb_any  output  1  OR of all pb_press bits, same cycle.

Function
REQ-013 SHALL pass each pb_in bit through a SYNC_STAGES flop chain; no other logic SHALL sample pb_in.
REQ-014 SHALL keep a per-channel counter of width $clog2(DEBOUNCE_CYCLES+1); it increments while the synced bit differs from pb_level and clears whenever they are equal.
REQ-015 SHALL update pb_level to the synced value on the cycle the counter reaches DEBOUNCE_CYCLES, then clear the counter; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave pb_level unchanged.
REQ-016 SHALL give a latency of exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles from a clean pb_in edge to the pb_level edge.
REQ-017 SHALL assert pb_press (pb_release) for exactly one cycle, registered, in the same cycle pb_level goes 0->1 (1->0).
REQ-018 SHALL treat channels independently; coincident pulses on several channels are legal and SHALL all appear.
REQ-019 SHALL never assert pb_press and pb_release on the same channel in the same cycle.

Reset
REQ-020 SHALL, while rst=1, drive pb_level, pb_press, pb_release, pb_any to 0 and clear synchronizers, counters, repeat timers and repeat state to IDLE.
REQ-021 SHALL, on reset asserted mid-press or mid-repeat, abort without emitting a release pulse.
REQ-022 SHALL, with a button held across reset release, report it as a fresh press after SYNC_STAGES + DEBOUNCE_CYCLES cycles.

Configuration
REQ-023 SHALL compile the auto-repeat feature only when macro PB_AUTOREPEAT_EN is defined.
REQ-024 SHALL, with PB_AUTOREPEAT_EN, run a per-channel FSM: IDLE -> (press) HOLD_DELAY, timer loaded REPEAT_DELAY -> (timer expiry) REPEAT with pb_press pulse, timer reloaded REPEAT_PERIOD -> each expiry pulses pb_press and reloads; pb_level falling returns to IDLE from any state with no repeat pulse that cycle.
REQ-025 SHALL, without PB_AUTOREPEAT_EN, contain no repeat timers or FSM; pb_press pulses only on pb_level rising.

Structure
REQ-026 SHALL place NUM_PB default, channel index constants (PB_UP, PB_DOWN, PB_LEFT, PB_RIGHT, PB_CENTER = 0..4) and the repeat-FSM state enum in shared package pb_pkg.
REQ-027 SHALL implement one channel (sync, debounce, edge detect, optional repeat) in sub-module pb_channel, instantiated NUM_PB times by generate; pb_any is formed at top of pb_conditioner.

Verification (bench: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-028 SHALL cover: rst=1 for 3 cycles with pb_in=5'b11111 -> all outputs 0 throughout; after release, pb_level=5'b11111 and pb_press=5'b11111 for one cycle exactly 6 cycles later.
REQ-029 SHALL cover: pb_in[0] 0->1 held 30 cycles, macro off -> pb_level[0] rises 6 cycles after edge, single pb_press[0] pulse, pb_any pulses same cycle; drop -> pb_release[0] pulse 6 cycles later.
REQ-030 SHALL cover: pb_in[2] high 3 cycles then low -> no change on any output.
REQ-031 SHALL cover: pb_in[1] toggling every 2 cycles for 12 cycles then held high -> exactly one pb_press[1], 6 cycles after the final edge.
REQ-032 SHALL cover: macro on, pb_in[4] held 60 cycles -> pb_press[4] at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (t0 = first press pulse), none after release.
REQ-033 SHALL cover: macro on, rst pulsed at t0+25 while pb_in[4] held -> outputs 0 during reset, no pb_release, fresh press 6 cycles after rst deasserts.
